// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block and its duty divider.
package pwm_pkg;

  localparam int DUTY_W = 32;
  localparam int CNT_W  = 32;

  localparam logic [DUTY_W-1:0] DUTY_FULL = 32'hffffffff;

  typedef enum logic [1:0] {
    ARM,
    RUN,
    STUCK
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pwm_capture_div.sv
// Restoring radix-2 divider producing floor(num * 2^32 / den), one quotient bit per cycle.
module pwm_duty_div
  import pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_i,
  input  logic [CNT_W-1:0]  den_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DUTY_W-1:0] quot_o
);

  logic [CNT_W:0]    rem_q, rem_d;
  logic [CNT_W-1:0]  den_q, den_d;
  logic [DUTY_W-1:0] quot_q, quot_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sat_q, sat_d;

  logic [CNT_W:0]    rem_sh;
  logic [CNT_W:0]    rem_sub;
  logic              fits;

  always_comb begin
    rem_sh  = {rem_q[CNT_W-1:0], 1'b0};
    rem_sub = rem_sh - {1'b0, den_q};
    fits    = (rem_sh >= {1'b0, den_q});

    rem_d  = rem_q;
    den_d  = den_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    sat_d  = sat_q;
    done_d = 1'b0;

    if (start_i) begin
      // num < den keeps the remainder below 2^32, so the quotient fits in 32 bits
      rem_d  = {1'b0, num_i};
      den_d  = den_i;
      quot_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
      sat_d  = (num_i >= den_i) || (den_i == '0);
    end else if (busy_q) begin
      rem_d  = fits ? rem_sub : rem_sh;
      quot_d = {quot_q[DUTY_W-2:0], fits};
      cnt_d  = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sat_q  <= sat_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = sat_q ? DUTY_FULL : quot_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period, high time and duty fraction between synced rising edges.
// Optional glitch filter after the synchronizer: define PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT     = 32'd1000000,
  parameter int               SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              busy,
  output logic              overrun,
  output logic              stuck,
  output logic              stuck_level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced, lvl, lvl_prev_q, rise;

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  logic [1:0] hist_q;
  // Level only moves once three consecutive samples agree on a new value
  assign lvl = (synced == hist_q[0] && synced == hist_q[1]) ? synced : lvl_prev_q;
`else
  assign lvl = synced;
`endif

  assign rise = lvl & ~lvl_prev_q;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]  cap_per_q, cap_per_d, cap_hi_q, cap_hi_d;
  logic [CNT_W-1:0]  period_q, period_d, high_q, high_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d, overrun_q, overrun_d;
  logic              stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;
  logic              div_start, div_busy, div_done;
  logic [DUTY_W-1:0] div_quot;

  assign per_cnt_d = rise ? CNT_W'(1) : sat_inc(per_cnt_q);
  assign hi_cnt_d  = rise ? CNT_W'(1) : (lvl ? sat_inc(hi_cnt_q) : hi_cnt_q);

  always_comb begin
    state_d     = state_q;
    div_start   = 1'b0;
    cap_per_d   = cap_per_q;
    cap_hi_d    = cap_hi_q;
    period_d    = period_q;
    high_d      = high_q;
    duty_d      = duty_q;
    valid_d     = 1'b0;
    overrun_d   = 1'b0;
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;

    if (div_done) begin
      period_d = cap_per_q;
      high_d   = cap_hi_q;
      duty_d   = div_quot;
      valid_d  = 1'b1;
    end

    case (state_q)
      ARM, RUN: begin
        if (rise) begin
          state_d = RUN;
          if (state_q == RUN) begin
            if (div_busy) begin
              overrun_d = 1'b1;
            end else begin
              div_start = 1'b1;
              cap_per_d = per_cnt_q;
              cap_hi_d  = hi_cnt_q;
            end
          end
        end else if (per_cnt_q == TIMEOUT) begin
          state_d     = STUCK;
          stuck_d     = 1'b1;
          stuck_lvl_d = lvl;
          period_d    = '0;
          high_d      = '0;
          duty_d      = lvl ? DUTY_FULL : '0;
          valid_d     = 1'b1;
        end
      end
      STUCK: begin
        // This edge only re-arms; the period it closes is not trustworthy
        if (rise) begin
          state_d = RUN;
          stuck_d = 1'b0;
        end
      end
      default: state_d = ARM;
    endcase
  end

  pwm_duty_div u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .num_i   (hi_cnt_q),
    .den_i   (per_cnt_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (div_quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      lvl_prev_q  <= 1'b0;
`ifdef PWM_CAPTURE_FILTER_EN
      hist_q      <= '0;
`endif
      state_q     <= ARM;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      cap_per_q   <= '0;
      cap_hi_q    <= '0;
      period_q    <= '0;
      high_q      <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      lvl_prev_q  <= lvl;
`ifdef PWM_CAPTURE_FILTER_EN
      hist_q      <= {hist_q[0], synced};
`endif
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      cap_per_q   <= cap_per_d;
      cap_hi_q    <= cap_hi_d;
      period_q    <= period_d;
      high_q      <= high_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_q;
  assign duty        = duty_q;
  assign valid       = valid_q;
  assign busy        = div_busy;
  assign overrun     = overrun_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Random and directed PWM waveforms checked against an edge-level reference model.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int T = 1000;
  localparam int N = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pwm_in = 1'b0;
  logic [31:0] period, high_time, duty;
  logic        valid, busy, overrun, stuck, stuck_level;

  always #500 clk = ~clk;

  pwm_capture #(.TIMEOUT(32'(T)), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .period      (period),
    .high_time   (high_time),
    .duty        (duty),
    .valid       (valid),
    .busy        (busy),
    .overrun     (overrun),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected outputs indexed by clock cycle
  bit          ev [N];
  bit          eo [N];
  bit          eb [N];
  bit          es [N];
  bit          el [N];
  logic [31:0] ep [N];
  logic [31:0] eh [N];
  logic [31:0] ed [N];
  logic [31:0] cur_p, cur_h, cur_d;

  // Model state: 0 = waiting for first edge, 1 = measuring, 2 = stuck
  int mstate, n_last, busy_free, hi_acc;
  bit y_prev, x1, x2, mstuck, mlvl;

  function automatic void clear_from(input int c);
    for (int i = c; i < N; i++) begin
      ev[i] = 1'b0; eo[i] = 1'b0; eb[i] = 1'b0; es[i] = 1'b0; el[i] = 1'b0;
      ep[i] = '0;   eh[i] = '0;   ed[i] = '0;
    end
  endfunction

  function automatic void sched(input int c, input logic [31:0] p, input logic [31:0] h,
                                input logic [31:0] d);
    ev[c] = 1'b1; ep[c] = p; eh[c] = h; ed[c] = d;
  endfunction

  // Sample n of the driven line; the DUT sees its edge 2 cycles later
  function automatic void model_step(input int n, input bit xv);
    bit y, rise;
    int p;
    longint unsigned q;
`ifdef PWM_CAPTURE_FILTER_EN
    y = (xv == x1 && x1 == x2) ? xv : y_prev;
`else
    y = xv;
`endif
    rise = y & ~y_prev;
    if (rise) begin
      if (mstate == 1) begin
        p = n - n_last;
        if (n + 2 >= busy_free) begin
          q = (hi_acc >= p) ? 64'hffffffff : ((64'(hi_acc) << 32) / 64'(p));
          sched(n + 36, 32'(p), 32'(hi_acc), q[31:0]);
          for (int k = n + 3; k <= n + 34; k++) eb[k] = 1'b1;
          busy_free = n + 35;
        end else begin
          eo[n + 3] = 1'b1;
        end
      end
      mstate = 1;
      mstuck = 1'b0;
      n_last = n;
      hi_acc = 1;
    end else begin
      hi_acc += int'(y);
      if (mstate != 2 && n - n_last == T) begin
        mstate = 2;
        mstuck = 1'b1;
        mlvl   = y;
        sched(n + 3, '0, '0, y ? 32'hffffffff : 32'h0);
      end
    end
    es[n + 3] = mstuck;
    el[n + 3] = mlvl;
    y_prev = y; x2 = x1; x1 = xv;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    if (ev[cyc]) begin
      cur_p = ep[cyc]; cur_h = eh[cyc]; cur_d = ed[cyc];
    end
    check("valid",       32'(valid),       32'(ev[cyc]));
    check("overrun",     32'(overrun),     32'(eo[cyc]));
    check("busy",        32'(busy),        32'(eb[cyc]));
    check("stuck",       32'(stuck),       32'(es[cyc]));
    check("stuck_level", 32'(stuck_level), 32'(el[cyc]));
    check("period",      period,           cur_p);
    check("high_time",   high_time,        cur_h);
    check("duty",        duty,             cur_d);
  endtask

  task automatic step(input bit v);
    @(posedge clk);
    cyc++;
    if (cyc > N - 64) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, N - 64);
      $fatal(1, "cycle budget exceeded");
    end
    #1 pwm_in = v;
    model_step(cyc, v);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      cyc++;
      #1 rst = 1'b1;
      pwm_in = 1'b0;
      if (i == 0) begin
        clear_from(cyc);
        cur_p = '0; cur_h = '0; cur_d = '0;
        mstate = 0; busy_free = 0; hi_acc = 0;
        y_prev = 1'b0; x1 = 1'b0; x2 = 1'b0; mstuck = 1'b0; mlvl = 1'b0;
      end
      @(negedge clk);
      check_all();
    end
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    pwm_in = 1'b0;
    n_last = cyc - 2;
    model_step(cyc, 1'b0);
    @(negedge clk);
    check_all();
  endtask

  task automatic wave(input int p, input int h, input int n);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < p; i++) step(i < h);
  endtask

  task automatic glitch_period(input int p, input int h, input int pos, input int len, input bit val);
    bit v;
    for (int i = 0; i < p; i++) begin
      v = (i < h);
      if (i >= pos && i < pos + len) v = val;
      step(v);
    end
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  initial begin
    int p, h;
    clear_from(0);
    cur_p = '0; cur_h = '0; cur_d = '0;

    do_reset(5);

    wave(100, 50, 5);
    wave(100, 25, 4);
    wave(3, 1, 40);

    for (int r = 0; r < 14; r++) begin
      p = int'($urandom_range(20, 150));
      h = int'($urandom_range(1, p - 1));
      wave(p, h, 1);
    end

    wave(100, 50, 2);
    glitch_period(100, 50, 70, 1, 1'b1);
    glitch_period(100, 50, 80, 2, 1'b1);
    glitch_period(100, 50, 20, 1, 1'b0);
    glitch_period(100, 50, 30, 2, 1'b0);
    wave(100, 50, 2);

    hold(1'b1, 1100);
    hold(1'b0, 20);
    wave(100, 50, 3);

    hold(1'b0, 1100);
    wave(100, 50, 3);

    wave(100, 50, 3);
    hold(1'b1, 10);
    do_reset(5);
    wave(100, 50, 3);

    hold(1'b0, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
